// File: rtl/csr_commit_ctrl.sv
// Write-back CSR/exception commit controller with flush + front-end drain.
// Optional PLV_CHECK_EN: privileged CSR/ertn ops at cur_plv!=0 raise IPE.
module csr_commit_ctrl #(
    parameter int          DRAIN_CYCLES = 2,
    parameter logic [5:0]  ECODE_INT    = 6'h0,
    parameter logic [5:0]  ECODE_IPE    = 6'hE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [2:0]  in_op,
    input  logic [13:0] in_csr_num,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_rj_value,
    input  logic [31:0] in_rkd_value,
    input  logic        in_ex,
    input  logic [5:0]  in_ecode,
    input  logic [8:0]  in_esubcode,
    input  logic [31:0] in_vaddr,
    input  logic [1:0]  cur_plv,
    input  logic        has_int,
    input  logic [31:0] csr_rvalue,
    input  logic [31:0] csr_eentry,
    output logic        csr_re,
    output logic [13:0] csr_num,
    output logic        csr_we,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_vaddr,
    output logic        ertn_flush,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flush_valid,
    output logic [31:0] flush_target
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t     state;
    logic [3:0] drain_cnt;

    logic fire;
    logic op_rd, op_wr, op_xchg, op_ertn, op_csr;
    logic plv_bad;
    logic int_hit, ex_hit, ipe_hit, exc_hit;
    logic ertn_hit, csr_hit, flush_hit;

    assign in_ready = (state == S_IDLE);
    assign fire     = in_valid & in_ready;

    assign op_rd   = (in_op == 3'd1);
    assign op_wr   = (in_op == 3'd2);
    assign op_xchg = (in_op == 3'd3);
    assign op_ertn = (in_op == 3'd4);
    assign op_csr  = op_rd | op_wr | op_xchg;

`ifdef PLV_CHECK_EN
    assign plv_bad = (cur_plv != 2'd0);
`else
    assign plv_bad = (|cur_plv) & 1'b0;
`endif

    // Mutually exclusive commit classes in priority order.
    assign int_hit   = fire & has_int;
    assign ex_hit    = fire & ~has_int & in_ex;
    assign ipe_hit   = fire & ~has_int & ~in_ex & plv_bad
                     & (op_csr | op_ertn);
    assign exc_hit   = int_hit | ex_hit | ipe_hit;
    assign ertn_hit  = fire & op_ertn & ~exc_hit;
    assign csr_hit   = fire & op_csr & ~exc_hit;
    assign flush_hit = exc_hit | ertn_hit;

    always_comb begin
        wb_ex       = exc_hit;
        wb_ecode    = 6'h0;
        wb_esubcode = 9'h0;
        wb_pc       = 32'h0;
        wb_vaddr    = 32'h0;
        unique case (1'b1)
            int_hit: begin
                wb_ecode = ECODE_INT;
                wb_pc    = in_pc;
            end
            ex_hit: begin
                wb_ecode    = in_ecode;
                wb_esubcode = in_esubcode;
                wb_pc       = in_pc;
                wb_vaddr    = in_vaddr;
            end
            ipe_hit: begin
                wb_ecode = ECODE_IPE;
                wb_pc    = in_pc;
            end
            default: ;
        endcase
    end

    always_comb begin
        ertn_flush = ertn_hit;
        csr_re     = ertn_hit | csr_hit;
        csr_num    = 14'h0;
        csr_we     = csr_hit & (op_wr | op_xchg);
        csr_wmask  = 32'h0;
        csr_wvalue = 32'h0;
        if (ertn_hit)
            csr_num = 14'h6;
        else if (csr_hit)
            csr_num = in_csr_num;
        if (csr_hit & op_wr)
            csr_wmask = 32'hFFFF_FFFF;
        else if (csr_hit & op_xchg)
            csr_wmask = in_rj_value;
        if (csr_we)
            csr_wvalue = in_rkd_value;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            drain_cnt    <= 4'd0;
            rf_we        <= 1'b0;
            rf_waddr     <= 5'd0;
            rf_wdata     <= 32'h0;
            flush_valid  <= 1'b0;
            flush_target <= 32'h0;
        end else begin
            rf_we       <= csr_hit;
            flush_valid <= 1'b0;
            if (csr_hit) begin
                rf_waddr <= in_rd;
                rf_wdata <= csr_rvalue;
            end
            unique case (state)
                S_IDLE: begin
                    if (flush_hit) begin
                        state        <= S_FLUSH;
                        flush_valid  <= 1'b1;
                        flush_target <= exc_hit ? csr_eentry : csr_rvalue;
                    end
                end
                S_FLUSH: begin
                    state     <= S_DRAIN;
                    drain_cnt <= 4'(DRAIN_CYCLES);
                end
                S_DRAIN: begin
                    if (drain_cnt <= 4'd1) begin
                        state     <= S_IDLE;
                        drain_cnt <= 4'd0;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Scoreboard bench for csr_commit_ctrl: directed vectors, decoupled monitor.
// Build with +define+PLV_CHECK_EN to exercise the privilege check vector.
module tb_csr_commit_ctrl;

    typedef struct {
        logic [2:0]  op;
        logic [13:0] num;
        logic [4:0]  rd;
        logic [31:0] rj;
        logic [31:0] rkd;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] vaddr;
        logic [31:0] pc;
        logic        hint;
        logic [31:0] rvalue;
        logic [31:0] eentry;
        logic [1:0]  plv;
    } stim_t;

    typedef struct {
        logic        wb_ex;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] pc;
        logic [31:0] vaddr;
        logic        ertn;
        logic        re;
        logic [13:0] num;
        logic        we;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        fv;
        logic [31:0] ft;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [2:0]  in_op;
    logic [13:0] in_csr_num;
    logic [4:0]  in_rd;
    logic [31:0] in_rj_value;
    logic [31:0] in_rkd_value;
    logic        in_ex;
    logic [5:0]  in_ecode;
    logic [8:0]  in_esubcode;
    logic [31:0] in_vaddr;
    logic [1:0]  cur_plv;
    logic        has_int;
    logic [31:0] csr_rvalue;
    logic [31:0] csr_eentry;
    logic        csr_re;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flush_valid;
    logic [31:0] flush_target;

    int   tests = 0;
    int   fails = 0;
    exp_t expq[$];

    always #5 clk = ~clk;

    csr_commit_ctrl dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_op(in_op), .in_csr_num(in_csr_num),
        .in_rd(in_rd), .in_rj_value(in_rj_value),
        .in_rkd_value(in_rkd_value), .in_ex(in_ex),
        .in_ecode(in_ecode), .in_esubcode(in_esubcode),
        .in_vaddr(in_vaddr), .cur_plv(cur_plv), .has_int(has_int),
        .csr_rvalue(csr_rvalue), .csr_eentry(csr_eentry),
        .csr_re(csr_re), .csr_num(csr_num), .csr_we(csr_we),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flush_valid(flush_valid), .flush_target(flush_target)
    );

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Monitor: comb outputs checked in the fire cycle, registered ones a cycle later.
    initial begin : monitor
        exp_t cur;
        logic pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("rf_we", rf_we, cur.rf_we);
                if (cur.rf_we) begin
                    chk("rf_waddr", rf_waddr, cur.waddr);
                    chk("rf_wdata", rf_wdata, cur.wdata);
                end
                chk("flush_valid", flush_valid, cur.fv);
                if (cur.fv)
                    chk("flush_target", flush_target, cur.ft);
                pend = 1'b0;
            end
            if (!reset && in_valid && in_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_fire", 1, 0);
                end else begin
                    cur = expq.pop_front();
                    chk("wb_ex", wb_ex, cur.wb_ex);
                    if (cur.wb_ex) begin
                        chk("wb_ecode", wb_ecode, cur.ecode);
                        chk("wb_esubcode", wb_esubcode, cur.esub);
                        chk("wb_pc", wb_pc, cur.pc);
                        chk("wb_vaddr", wb_vaddr, cur.vaddr);
                    end
                    chk("ertn_flush", ertn_flush, cur.ertn);
                    chk("csr_re", csr_re, cur.re);
                    chk("csr_we", csr_we, cur.we);
                    if (cur.re) begin
                        chk("csr_num", csr_num, cur.num);
                        chk("csr_wmask", csr_wmask, cur.wmask);
                        chk("csr_wvalue", csr_wvalue, cur.wvalue);
                    end
                    pend = 1'b1;
                end
            end else if (!reset) begin
                chk("idle_outputs",
                    {wb_ex, csr_re, csr_we, ertn_flush}, 4'b0);
            end
        end
    end

    task automatic issue(input stim_t s, input exp_t e);
        int n;
        in_op        = s.op;
        in_csr_num   = s.num;
        in_rd        = s.rd;
        in_rj_value  = s.rj;
        in_rkd_value = s.rkd;
        in_ex        = s.ex;
        in_ecode     = s.ecode;
        in_esubcode  = s.esub;
        in_vaddr     = s.vaddr;
        in_pc        = s.pc;
        has_int      = s.hint;
        csr_rvalue   = s.rvalue;
        csr_eentry   = s.eentry;
        cur_plv      = s.plv;
        in_valid     = 1'b1;
        expq.push_back(e);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 0, 1);
            void'(expq.pop_back());
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        has_int  = 1'b0;
    endtask

    stim_t s;
    exp_t  e;

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_pc = 0; in_op = 0; in_csr_num = 0; in_rd = 0;
        in_rj_value = 0; in_rkd_value = 0; in_ex = 0; in_ecode = 0;
        in_esubcode = 0; in_vaddr = 0; cur_plv = 0; has_int = 0;
        csr_rvalue = 0; csr_eentry = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_flush_valid", flush_valid, 0);
        chk("reset_rf_we", rf_we, 0);
        @(posedge clk);
        #1;

        // csrwr then csrxchg back-to-back, then csrrd
        s = '{2, 14'h30, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0, 32'h1C000000, 0, 32'h12345678, 32'h1C008000, 0};
        e = '{0, 0, 0, 0, 0, 0, 1, 14'h30, 1, 32'hFFFFFFFF, 32'hDEADBEEF, 1, 5, 32'h12345678, 0, 0};
        issue(s, e);
        s = '{3, 14'h4, 7, 32'hFFF, 32'h801, 0, 0, 0, 0, 32'h1C000004, 0, 32'hAAAA5555, 32'h1C008000, 0};
        e = '{0, 0, 0, 0, 0, 0, 1, 14'h4, 1, 32'hFFF, 32'h801, 1, 7, 32'hAAAA5555, 0, 0};
        issue(s, e);
        s = '{1, 14'h5, 3, 32'h1, 32'h5555, 0, 0, 0, 0, 32'h1C000008, 0, 32'h11112222, 32'h1C008000, 0};
        e = '{0, 0, 0, 0, 0, 0, 1, 14'h5, 0, 0, 0, 1, 3, 32'h11112222, 0, 0};
        issue(s, e);
        @(negedge clk);
        chk("ready_after_csr_ops", in_ready, 1);
        @(posedge clk);
        #1;

        // exception: ready low for exactly 1+DRAIN_CYCLES cycles
        s = '{2, 14'h30, 4, 0, 32'h1234, 1, 6'h9, 0, 32'h1003, 32'h1C000100, 0, 32'h99, 32'h1C008000, 0};
        e = '{1, 6'h9, 0, 32'h1C000100, 32'h1003, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1C008000};
        issue(s, e);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain_ready_low", in_ready, 0);
        end
        @(negedge clk);
        chk("drain_ready_back", in_ready, 1);
        @(posedge clk);
        #1;

        // ertn redirects to ERA
        s = '{4, 0, 9, 0, 0, 0, 0, 0, 0, 32'h1C000300, 0, 32'h1C000200, 32'h1C008000, 0};
        e = '{0, 0, 0, 0, 0, 1, 1, 14'h6, 0, 0, 0, 0, 0, 0, 1, 32'h1C000200};
        issue(s, e);

        // interrupt beats an in-flight exception and suppresses the write
        s = '{2, 14'h30, 5, 0, 32'hDEADBEEF, 1, 6'h9, 9'h3, 32'h77, 32'h1C000400, 1, 32'h5, 32'h1C00A000, 0};
        e = '{1, 0, 0, 32'h1C000400, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1C00A000};
        issue(s, e);

        // reserved op is a no-op; csrwr to r0 still asserts rf_we
        s = '{6, 14'h30, 5, 32'hF, 32'hF, 0, 0, 0, 0, 32'h1C000500, 0, 32'h5, 32'h1C008000, 0};
        e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        issue(s, e);
        s = '{2, 14'h1, 0, 0, 32'hCAFE, 0, 0, 0, 0, 32'h1C000504, 0, 32'h42, 32'h1C008000, 0};
        e = '{0, 0, 0, 0, 0, 0, 1, 14'h1, 1, 32'hFFFFFFFF, 32'hCAFE, 1, 0, 32'h42, 0, 0};
        issue(s, e);

        // csrrd at PLV3
        s = '{1, 14'h5, 2, 0, 0, 0, 0, 0, 0, 32'h1C000600, 0, 32'h77, 32'h1C00C000, 3};
`ifdef PLV_CHECK_EN
        e = '{1, 6'hE, 0, 32'h1C000600, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1C00C000};
`else
        e = '{0, 0, 0, 0, 0, 0, 1, 14'h5, 0, 0, 0, 1, 2, 32'h77, 0, 0};
`endif
        issue(s, e);

        // reset while draining
        s = '{0, 0, 0, 0, 0, 1, 6'h8, 0, 32'h2000, 32'h1C000700, 0, 32'h0, 32'h1C008000, 0};
        e = '{1, 6'h8, 0, 32'h1C000700, 32'h2000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1C008000};
        issue(s, e);
        @(negedge clk);
        chk("in_drain_ready", in_ready, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("drain_reset_ready", in_ready, 1);
        chk("drain_reset_flush_valid", flush_valid, 0);
        chk("drain_reset_flush_target", flush_target, 0);
        chk("drain_reset_rf_we", rf_we, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/csr_commit_ctrl.md
Name: csr_commit_ctrl

Overview:
- Write-back-stage initiator for the CSR file's access and exception interface.
- Accepts one retiring instruction per handshake and turns it into the CSR file's signals:
  - CSR read/write (csr_re/csr_num/csr_we/csr_wmask/csr_wvalue)
  - exception commit (wb_ex/wb_ecode/wb_esubcode/wb_pc/wb_vaddr)
  - ertn_flush
- Also produces the register-file writeback of the old CSR value and a pipeline flush/redirect, then holds off intake while the front end drains.

Parameters:
DRAIN_CYCLES, 2, cycles in_ready stays low after a flush pulse (1..15)
ECODE_INT, 6'h0, ecode committed for an interrupt
ECODE_IPE, 6'hE, ecode for privilege violation (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  retiring instruction valid
in_ready  out  1  controller can accept
in_pc  in  32  instruction PC
in_op  in  3  0 none, 1 csrrd, 2 csrwr, 3 csrxchg, 4 ertn; 5-7 treated as none
in_csr_num  in  14  CSR index
in_rd  in  5  destination register
in_rj_value  in  32  csrxchg write mask
in_rkd_value  in  32  csrwr/csrxchg write data
in_ex  in  1  instruction carries a pipeline exception
in_ecode  in  6  its ecode
in_esubcode  in  9  its esubcode
in_vaddr  in  32  faulting data address
cur_plv  in  2  current privilege level (ignored without optional feature)
has_int  in  1  pending enabled interrupt from CSR file
csr_rvalue  in  32  CSR read data (combinational)
csr_eentry  in  32  exception entry
csr_re  out  1  CSR read enable
csr_num  out  14  CSR index
csr_we  out  1  CSR write enable
csr_wmask  out  32  write mask
csr_wvalue  out  32  write data
wb_ex  out  1  exception commit pulse
wb_ecode  out  6  committed ecode
wb_esubcode  out  9  committed esubcode
wb_pc  out  32  committed PC
wb_vaddr  out  32  committed bad address
ertn_flush  out  1  ertn commit pulse
rf_we  out  1  register write, registered
rf_waddr  out  5  register index, registered
rf_wdata  out  32  old CSR value, registered
flush_valid  out  1  one-cycle redirect pulse, registered
flush_target  out  32  redirect PC, registered

Behaviour:
- Accept cycle: fire = in_valid & in_ready. All CSR-side outputs are combinational from the fire cycle's inputs and are 0 when fire=0.
- Priority within fire:
  1. has_int: wb_ex=1, wb_ecode=ECODE_INT, wb_esubcode=0, wb_pc=in_pc, wb_vaddr=0.
  2. in_ex: wb_ex=1 with in_ecode/in_esubcode/in_pc/in_vaddr.
  3. ertn: ertn_flush=1, csr_re=1, csr_num=14'h6 (ERA).
  4. csr op: csr_re=1, csr_num=in_csr_num, csr_we=1 for ops 2/3.
- Interrupts and exceptions suppress csr_we, ertn_flush and rf_we.
- Write encoding:
  - csrwr: wmask=32'hFFFFFFFF, wvalue=in_rkd_value.
  - csrxchg: wmask=in_rj_value, wvalue=in_rkd_value.
  - csrrd: we=0, wmask=0, wvalue=0.
- Writeback: for ops 1-3 without ex/int, the next cycle has rf_we=1, rf_waddr=in_rd, and rf_wdata=csr_rvalue sampled in the fire cycle (pre-write value). rf_waddr=0 still asserts rf_we; the register file drops it.
- Flush: on exception/interrupt, flush_target=csr_eentry sampled in the fire cycle; on ertn, flush_target=csr_rvalue (ERA). flush_valid pulses high for exactly one cycle, the cycle after fire.
- FSM:
  - IDLE: in_ready=1. A flushing fire goes to FLUSH; any other fire stays in IDLE.
  - FLUSH: one cycle, in_ready=0, flush_valid=1, loads drain_cnt=DRAIN_CYCLES, then goes to DRAIN.
  - DRAIN: in_ready=0, decrement drain_cnt; return to IDLE when it reaches 1. in_ready rises on the following cycle.
  - Minimum spacing between two flush fires is 2+DRAIN_CYCLES cycles.
- Back-to-back non-flushing ops: one per cycle, no bubbles.
- has_int is sampled only at fire. Interrupts raised during FLUSH/DRAIN are taken on the next accepted instruction.
- Reset (any state, including mid-DRAIN): state=IDLE, drain_cnt=0, and all registered outputs cleared (rf_we, rf_waddr, rf_wdata, flush_valid, flush_target=0). in_ready=1 on the first cycle after reset deasserts.

Optional Feature:
PLV_CHECK_EN:
- Defined: ops 2-4 and csrrd with cur_plv!=0 (no higher-priority ex/int) commit wb_ex with ECODE_IPE, esubcode 0, vaddr 0. csr_re, csr_we and rf_we are suppressed, and the controller flushes to csr_eentry.
- Undefined: cur_plv is ignored; privilege is not checked.

Test Plan:
1. csrwr, num=14'h30, rkd=32'hDEADBEEF, csr_rvalue=32'h12345678, rd=5 -> same cycle csr_we=1, wmask=FFFFFFFF, wvalue=DEADBEEF; next cycle rf_we=1, waddr=5, wdata=12345678; in_ready stays 1.
2. csrxchg, num=14'h4, rj=32'h00000FFF, rkd=32'h00000801 -> wmask=00000FFF, wvalue=00000801, rf_we next cycle.
3. in_ex=1, ecode=6'h9, vaddr=32'h1003, pc=32'h1C000100, csr_eentry=32'h1C008000 -> wb_ex pulse with those values, csr_we=0; next cycle flush_valid=1, target=1C008000; in_ready low for 1+DRAIN_CYCLES=3 cycles.
4. ertn with csr_rvalue=32'h1C000200 -> ertn_flush=1, csr_num=6; flush_target=1C000200 next cycle, no rf_we.
5. csrwr with has_int=1 -> wb_ex=1, ecode=0, csr_we=0, rf_we=0, flush to csr_eentry.
6. Reset asserted in DRAIN -> next cycle in_ready=1, flush_valid=0, rf_we=0. Under PLV_CHECK_EN, csrrd with cur_plv=3 -> wb_ex, ecode=6'hE.
